instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program-counter and memory-address width.
REQ-002 SHALL have parameter INSTR_W, default 12, instruction width (4-bit opcode in [11:8], 8-bit operand in [7:0]).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port run, input, 1, fetch enable.
REQ-006 SHALL have port jump_en, input, 1, load the PC from jump_addr.
REQ-007 SHALL have port jump_addr, input, ADDR_W, branch target.
REQ-008 SHALL have port mem_addr, output, ADDR_W, instruction-memory word address.
REQ-009 SHALL have port mem_rd, output, 1, read request.
REQ-010 SHALL have port mem_rdata, input, INSTR_W, read data, valid when mem_ack=1.
REQ-011 SHALL have port mem_ack, input, 1, read completion, sampled only while mem_rd=1.
REQ-012 SHALL have port ir, output, INSTR_W, instruction register feeding the opcode/operand split stage.
REQ-013 SHALL have port ir_valid, output, 1, ir holds an unconsumed instruction.
REQ-014 SHALL have port ir_ready, input, 1, downstream accepts ir this cycle.
REQ-015 SHALL have port pc, output, ADDR_W, address of the instruction currently in ir.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, REQ, HOLD.
REQ-017 IDLE: mem_rd=0, ir_valid=0; when run=1, SHALL go to REQ next cycle.
REQ-018 REQ: mem_rd=1, mem_addr=fetch PC; on mem_ack=1 SHALL latch mem_rdata into ir, set pc to the fetch address, and go to HOLD; ir_valid rises the cycle after ack.
REQ-019 HOLD: ir_valid=1, ir stable; on ir_ready=1 SHALL advance the fetch PC by 1, then go to REQ if run=1, else IDLE.
REQ-020 The fetch PC SHALL wrap from all-ones to 0 with no flag.
REQ-021 mem_ack while mem_rd=0 SHALL be ignored.
REQ-022 jump_en in IDLE SHALL load the fetch PC with jump_addr and leave the state unchanged.
REQ-023 jump_en in HOLD SHALL drop ir_valid next cycle, load the fetch PC with jump_addr, and go to REQ, or to IDLE if run=0; ir_ready in the same cycle SHALL be ignored.
REQ-024 jump_en in REQ SHALL load the fetch PC with jump_addr and set a flush flag; the next ack SHALL be discarded, leaving ir unchanged and ir_valid at 0, and the FSM SHALL re-issue REQ at the new address.
REQ-025 jump_en and mem_ack in the same REQ cycle SHALL discard the data and re-request at jump_addr.
REQ-026 A second jump_en while flush is pending SHALL overwrite the target; only one discard SHALL occur.
REQ-027 run deasserted in REQ SHALL NOT abort the request; the FSM SHALL complete into HOLD and stop after the handshake.

Reset
REQ-028 rst=1 SHALL force IDLE, fetch PC=0, pc=0, ir=0, ir_valid=0, mem_rd=0, and flush=0 at the next edge, in any state, including mid-REQ; a late ack after reset SHALL be ignored.
REQ-029 rst SHALL override run and jump_en.

Structure
REQ-030 State encodings and ADDR_W/INSTR_W defaults SHALL live in the shared CPU definitions header.
REQ-031 The PC SHALL be a separate sub-module pc_counter, providing load, increment, and synchronous clear.

Verification
REQ-032 Reset, then run=1 with 0-wait memory returning 12'hA05 at address 0 and ir_ready=1 -> mem_rd at cycle 1, ir=12'hA05 with ir_valid=1 at cycle 3, next mem_addr=1.
REQ-033 Hold ir_ready=0 for 5 cycles -> ir and ir_valid stable; no new mem_rd until ir_ready=1.
REQ-034 Fetch PC=8'hFF, accept the instruction -> next mem_addr=8'h00.
REQ-035 jump_en with jump_addr=8'h40 during an outstanding REQ, ack 2 cycles later -> data discarded, ir_valid stays 0, next mem_addr=8'h40, pc=8'h40 once that data arrives.
REQ-036 rst during REQ, then ack one cycle later -> IDLE, ir=0, ir_valid=0, mem_rd=0, late ack ignored.
REQ-037 run=0 while in REQ -> one instruction delivered, then IDLE with mem_rd=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared CPU definitions: fetch-FSM state encodings, bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

    localparam int C_ADDR_W  = 8;
    localparam int C_INSTR_W = 12;
    localparam int C_STATE_W = 2;

    localparam logic [C_STATE_W-1:0] C_ST_IDLE = 2'd0;
    localparam logic [C_STATE_W-1:0] C_ST_REQ  = 2'd1;
    localparam logic [C_STATE_W-1:0] C_ST_HOLD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_pc_counter.sv
// ============================================================================
// Module      : pc_counter
// Description : Fetch program counter with synchronous clear, load, increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Load beats increment; increment wraps naturally from all-ones to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit: IDLE/REQ/HOLD FSM with jump flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W  = C_ADDR_W,
    parameter int INSTR_W = C_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [ADDR_W-1:0]  pc
);

    logic [C_STATE_W-1:0] r_state;
    logic [C_STATE_W-1:0] w_state_nxt;
    logic [INSTR_W-1:0]   r_ir;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_fetch_pc;
    logic                 r_flush;
    logic                 w_flush_nxt;
    logic                 w_pc_load;
    logic                 w_pc_inc;
    logic                 w_latch;

    pc_counter #(
        .WIDTH (ADDR_W)
    ) u_pc_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pc_load),
        .i_inc      (w_pc_inc),
        .i_load_val (jump_addr),
        .o_count    (w_fetch_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
            r_flush <= 1'b0;
            r_ir    <= '0;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_flush <= w_flush_nxt;
            if (w_latch) begin
                r_ir <= mem_rdata;
                r_pc <= w_fetch_pc;
            end
        end
    end

    // A jump during REQ discards exactly one ack: the one in the same cycle,
    // or else the next one (flush). Further jumps only retarget the PC.
    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = r_flush;
        w_pc_load   = jump_en;
        w_pc_inc    = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            C_ST_IDLE: begin
                if (!jump_en && run) begin
                    w_state_nxt = C_ST_REQ;
                end
            end
            C_ST_REQ: begin
                if (jump_en) begin
                    w_flush_nxt = !mem_ack;
                end else if (mem_ack) begin
                    if (r_flush) begin
                        w_flush_nxt = 1'b0;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = C_ST_HOLD;
                    end
                end
            end
            C_ST_HOLD: begin
                if (jump_en) begin
                    w_state_nxt = run ? C_ST_REQ : C_ST_IDLE;
                end else if (ir_ready) begin
                    w_pc_inc    = 1'b1;
                    w_state_nxt = run ? C_ST_REQ : C_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = C_ST_IDLE;
                w_flush_nxt = 1'b0;
                w_pc_load   = 1'b0;
            end
        endcase
    end

    always_comb begin
        mem_rd   = (r_state == C_ST_REQ);
        ir_valid = (r_state == C_ST_HOLD);
        mem_addr = w_fetch_pc;
        ir       = r_ir;
        pc       = r_pc;
    end

endmodule

`default_nettype wire
